// File: rtl/debounce_multi.sv
// Multi-channel button conditioner: polarity fix, 2-FF synchronizer, debounce filter,
// press/release pulses and long-press / auto-repeat events, independent per channel.
module debounce_multi #(
    parameter int unsigned CHANNELS         = 4,
    parameter int unsigned DEBOUNCE_CYCLES  = 50000,
    parameter int unsigned LONG_CYCLES      = 50000000,
    parameter int unsigned REPEAT_CYCLES    = 10000000,
    parameter bit          INPUT_ACTIVE_LOW = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [CHANNELS-1:0] btn_raw_i,
    output logic [CHANNELS-1:0] db_sig_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] long_evt_o
);
    localparam int unsigned CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HoldMax = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HoldW   = (HoldMax > 0) ? $clog2(HoldMax + 1) : 1;

    localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] LongTgt = HoldW'(LONG_CYCLES);
    localparam logic [HoldW-1:0] RepTgt  = HoldW'(REPEAT_CYCLES);
    localparam bit               LongEn  = (LONG_CYCLES != 0);
    localparam bit               RepEn   = (REPEAT_CYCLES != 0);

    typedef enum logic [1:0] {StLow, StWaitHigh, StHigh, StWaitLow} state_e;

    logic [CHANNELS-1:0] btn_fix;
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;

    assign btn_fix = btn_raw_i ^ {CHANNELS{INPUT_ACTIVE_LOW}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_fix;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_e           state_q;
        logic [CntW-1:0]  cnt_q;
        logic [HoldW-1:0] hold_q;
        logic [HoldW-1:0] hold_d;
        logic [HoldW-1:0] hold_inc;
        logic             fired_q;
        logic             fired_d;
        logic             long_d;
        logic             held;
        logic             rel_now;
        logic             db_q;
        logic             press_q;
        logic             release_q;
        logic             long_q;

        assign held     = (state_q == StHigh) || (state_q == StWaitLow);
        assign rel_now  = (state_q == StWaitLow) && !sync2_q[g] && (cnt_q == CntLast);
        assign hold_inc = hold_q + HoldW'(1);

        // Hold counter keeps running through WAIT_LOW so a release bounce does not restart it;
        // fired_q selects between the first long target and the repeat period.
        always_comb begin
            hold_d  = hold_q;
            fired_d = fired_q;
            long_d  = 1'b0;
            if (!LongEn || !held || rel_now) begin
                hold_d  = '0;
                fired_d = 1'b0;
            end else if (fired_q && !RepEn) begin
                hold_d = hold_q;
            end else if (hold_inc == (fired_q ? RepTgt : LongTgt)) begin
                hold_d  = '0;
                fired_d = 1'b1;
                long_d  = 1'b1;
            end else begin
                hold_d = hold_inc;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q   <= StLow;
                cnt_q     <= '0;
                hold_q    <= '0;
                fired_q   <= 1'b0;
                db_q      <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= long_d;
                hold_q    <= hold_d;
                fired_q   <= fired_d;
                unique case (state_q)
                    StLow: begin
                        if (sync2_q[g]) begin
                            state_q <= StWaitHigh;
                            cnt_q   <= CntW'(1);
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    StWaitHigh: begin
                        if (!sync2_q[g]) begin
                            state_q <= StLow;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q <= StHigh;
                            cnt_q   <= '0;
                            db_q    <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    StHigh: begin
                        if (!sync2_q[g]) begin
                            state_q <= StWaitLow;
                            cnt_q   <= CntW'(1);
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    StWaitLow: begin
                        if (sync2_q[g]) begin
                            state_q <= StHigh;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q   <= StLow;
                            cnt_q     <= '0;
                            db_q      <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    default: begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign db_sig_o[g]   = db_q;
        assign press_o[g]    = press_q;
        assign release_o[g]  = release_q;
        assign long_evt_o[g] = long_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: a window-based reference model predicts every cycle,
// a monitor compares both an active-high and an active-low instance against it.
module tb_debounce_multi;
    localparam int unsigned CH   = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;
    localparam int unsigned REP  = 8;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [CH-1:0] btn_raw = '0;
    logic [CH-1:0] btn_n;
    logic [CH-1:0] db, pr, rl, lg;
    logic [CH-1:0] db_al, pr_al, rl_al, lg_al;

    assign btn_n = ~btn_raw;

    always #5 clk = ~clk;

    debounce_multi #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP),
        .INPUT_ACTIVE_LOW(1'b0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .btn_raw_i(btn_raw),
        .db_sig_o(db), .press_o(pr), .release_o(rl), .long_evt_o(lg)
    );

    debounce_multi #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP),
        .INPUT_ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk_i(clk), .rst_ni(rst_n), .btn_raw_i(btn_n),
        .db_sig_o(db_al), .press_o(pr_al), .release_o(rl_al), .long_evt_o(lg_al)
    );

    typedef struct packed {
        logic [CH-1:0] db;
        logic [CH-1:0] pr;
        logic [CH-1:0] rl;
        logic [CH-1:0] lg;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: a two-sample delay line, the last DEB synchronized samples,
    // the accepted level and the age of the current press.
    bit          pipe[CH][$];
    bit          win[CH][$];
    bit          m_db[CH];
    int unsigned age[CH];

    task automatic reset_model();
        for (int c = 0; c < CH; c++) begin
            pipe[c].delete();
            pipe[c].push_back(1'b0);
            pipe[c].push_back(1'b0);
            win[c].delete();
            m_db[c] = 1'b0;
            age[c]  = 0;
        end
    endtask

    initial begin : model
        logic          r_edge;
        logic [CH-1:0] b_edge;
        out_t          e;
        bit            s;
        bit            flip;
        reset_model();
        forever begin
            @(posedge clk);
            r_edge = rst_n;
            b_edge = btn_raw;
            #2;
            e = '0;
            if (!r_edge || !rst_n) begin
                reset_model();
            end else begin
                for (int c = 0; c < CH; c++) begin
                    pipe[c].push_back(b_edge[c]);
                    s = pipe[c].pop_front();
                    win[c].push_back(s);
                    if (win[c].size() > DEB) void'(win[c].pop_front());
                    flip = (win[c].size() == DEB);
                    for (int k = 0; k < win[c].size(); k++)
                        if (win[c][k] == m_db[c]) flip = 1'b0;
                    if (flip) begin
                        m_db[c] = !m_db[c];
                        age[c]  = 0;
                        if (m_db[c]) e.pr[c] = 1'b1;
                        else e.rl[c] = 1'b1;
                    end else if (m_db[c]) begin
                        age[c]++;
                        if (age[c] >= LONG && ((age[c] - LONG) % REP) == 0) e.lg[c] = 1'b1;
                    end
                    e.db[c] = m_db[c];
                end
            end
            exp_q.push_back(e);
        end
    end

    task automatic compare(input string name, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got db=%b press=%b release=%b long=%b want db=%b press=%b release=%b long=%b",
                     name, $time, got.db, got.pr, got.rl, got.lg,
                     want.db, want.pr, want.rl, want.lg);
        end
    endtask

    initial begin : monitor
        out_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compare("active_high", {db, pr, rl, lg}, e);
                compare("active_low", {db_al, pr_al, rl_al, lg_al}, e);
            end
        end
    end

    task automatic drive(input logic [CH-1:0] b, input logic r, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            btn_raw = b;
            rst_n   = r;
        end
    endtask

    initial begin : stim
        logic [CH-1:0] b;
        logic          r;
        int            n;
        // Reset with both buttons held, then release reset while still held.
        drive(2'b11, 1'b0, 4);
        drive(2'b11, 1'b1, 12);
        drive(2'b00, 1'b1, 12);
        // Bounce on ch0, then a stable press.
        drive(2'b01, 1'b1, 1);
        drive(2'b00, 1'b1, 1);
        drive(2'b01, 1'b1, 1);
        drive(2'b00, 1'b1, 1);
        drive(2'b01, 1'b1, 12);
        drive(2'b00, 1'b1, 10);
        // Threshold on ch1: 3 cycles rejected, 4 cycles accepted.
        drive(2'b10, 1'b1, 3);
        drive(2'b00, 1'b1, 10);
        drive(2'b10, 1'b1, 4);
        drive(2'b00, 1'b1, 12);
        // Long press with repeats, then a release with a bounce.
        drive(2'b01, 1'b1, 56);
        drive(2'b00, 1'b1, 2);
        drive(2'b01, 1'b1, 1);
        drive(2'b00, 1'b1, 12);
        // Independence: ch0 held while ch1 bounces.
        drive(2'b01, 1'b1, 3);
        repeat (6) begin
            drive(2'b11, 1'b1, 1);
            drive(2'b01, 1'b1, 2);
        end
        drive(2'b01, 1'b1, 10);
        drive(2'b00, 1'b1, 10);
        // Reset in the middle of qualification; the held press re-qualifies.
        drive(2'b01, 1'b1, 4);
        drive(2'b01, 1'b0, 2);
        drive(2'b01, 1'b1, 12);
        drive(2'b00, 1'b1, 10);
        // Randomized patterns, occasional long holds and resets.
        repeat (80) begin
            b = CH'($urandom);
            n = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 6);
            r = ($urandom_range(0, 30) != 0);
            drive(b, r, n);
        end
        drive(2'b00, 1'b1, 12);
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
